// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB slave holding a small word-addressed register file:
//   idx 0            : read-only ID constant (ID_VALUE)
//   idx 1            : read-only count of completed transfers (wraps)
//   idx 2..NUM_REGS-1: read/write registers; idx 2 is exported on ctrl_o
// Every transfer is answered after a fixed number of wait states.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   psel_i     APB select
//   penable_i  APB enable (access phase)
//   paddr_i    byte address; word index is paddr_i[7:2]
//   pwrite_i   1 = write, 0 = read
//   pwdata_i   write data
//   pready_o   transfer completes when psel_i & penable_i & pready_o
//   prdata_o   read data, nonzero only with pready_o on a legal read
//   pslverr_o  error response (illegal address), valid with pready_o
//   ctrl_o     current contents of register 2
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic [31:0] ctrl_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wait_reg;
  logic [31:0] cnt_reg;

  // Decode is done on the captured address so that bus changes during the
  // access phase cannot alter the response of a transfer already in flight.
  logic [5:0] idx;
  logic       addr_legal;
  logic       done;

  assign idx        = addr_reg[7:2];
  assign addr_legal = (addr_reg[1:0] == 2'b00) &&
                      (addr_reg[31:8] == 24'd0) &&
                      ({1'b0, idx} < 7'(NUM_REGS));

  // pready is a decode of registered state only, so with zero wait states it
  // rises in the very first ACCESS cycle.
  assign pready_o = (state_reg == ACCESS) && (wait_reg == 4'd0);
  assign done     = pready_o && psel_i && penable_i;

  // ---------------------------------------------------------------------------
  // Transfer FSM, request capture, wait counter and transfer counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      wait_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // An enable without a preceding setup cycle is not a transfer.
          if (psel_i && !penable_i) begin
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          addr_reg  <= paddr_i;
          write_reg <= pwrite_i;
          wdata_reg <= pwdata_i;
          wait_reg  <= 4'(WAIT_STATES);
          state_reg <= psel_i ? ACCESS : IDLE;
        end
        ACCESS: begin
          if (!psel_i) begin
            // Master abandoned the transfer: no write, no count.
            state_reg <= IDLE;
          end else if (wait_reg != 4'd0) begin
            wait_reg <= wait_reg - 4'd1;
          end else if (penable_i) begin
            // Completion. A back-to-back setup cycle from the master arrives
            // in the next cycle and is picked up from IDLE without loss.
            cnt_reg   <= cnt_reg + 32'd1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file view: packed so each generate branch drives its own word
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0][31:0] reg_file;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign reg_file[gi] = ID_VALUE;
      end else if (gi == 1) begin : g_cnt
        assign reg_file[gi] = cnt_reg;
      end else begin : g_rw
        logic [31:0] word_reg;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            word_reg <= '0;
          end else if (done && write_reg && addr_legal && (idx == 6'(gi))) begin
            word_reg <= wdata_reg;
          end
        end
        assign reg_file[gi] = word_reg;
      end
    end
  endgenerate

  assign ctrl_o = reg_file[2];

  // ---------------------------------------------------------------------------
  // Read path. CNT reads its pre-increment value because the counter only
  // moves on the completion edge.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 6'(i)) begin
        rd_word = reg_file[i];
      end
    end
  end

  assign prdata_o  = (pready_o && !write_reg && addr_legal) ? rd_word : 32'd0;
  assign pslverr_o = pready_o && !addr_legal;

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pready0, pslverr0, pready1, pslverr1;
  logic [31:0] prdata0, ctrl0, prdata1, ctrl1;

  always #5 clk = ~clk;

  // dut0: default build (2 wait states); dut1: zero-wait-state build.
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(ID)) dut0 (
    .clk(clk), .reset(reset), .psel_i(psel0), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0), .ctrl_o(ctrl0)
  );

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) dut1 (
    .clk(clk), .reset(reset), .psel_i(psel1), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready1), .prdata_o(prdata1), .pslverr_o(pslverr1), .ctrl_o(ctrl1)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs[2][8];
  logic [31:0] m_cnt[2];
  int          m_ws[2] = '{2, 0};

  function automatic logic get_pready(int d);
    return (d == 0) ? pready0 : pready1;
  endfunction
  function automatic logic [31:0] get_prdata(int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction
  function automatic logic get_pslverr(int d);
    return (d == 0) ? pslverr0 : pslverr1;
  endfunction
  function automatic logic [31:0] get_ctrl(int d);
    return (d == 0) ? ctrl0 : ctrl1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0;
      for (int i = 0; i < 8; i++) m_regs[d][i] = '0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge with
  // the bus idle, so consecutive calls form back-to-back transfers.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd);
    exp_t        e;
    logic        legal;
    int          ix;
    int          cyc;
    logic        got;
    logic [31:0] ctrl_before;
    ix    = int'(a[7:2]);
    legal = (a[1:0] == 2'b00) && (a[31:8] == 24'd0) && (ix < 8);
    e.err = !legal;
    e.lat = m_ws[d] + 2;
    e.rdata = '0;
    if (legal && !w) e.rdata = (ix == 0) ? ID : (ix == 1) ? m_cnt[d] : m_regs[d][ix];
    sb.push_back(e);
    ctrl_before = m_regs[d][2];

    psel0 = (d == 0); psel1 = (d == 1);
    penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    @(posedge clk); #1 penable = 1'b1;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      // Request is captured by now; later bus changes must be ignored.
      if (cyc == 2) begin paddr = ~a; pwdata = ~wd; end
      if (get_pready(d)) got = 1'b1;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc), 32'(e.lat));
    check("prdata", get_prdata(d), e.rdata);
    check("pslverr", {31'd0, get_pslverr(d)}, {31'd0, e.err});
    check("ctrl_pre", get_ctrl(d), ctrl_before);
    $display("xfer dut%0d %s addr=%h wdata=%h prdata=%h pslverr=%0b cycles=%0d",
             d, w ? "WR" : "RD", a, wd, get_prdata(d), get_pslverr(d), cyc);
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0;
    if (got) begin
      m_cnt[d] = m_cnt[d] + 32'd1;
      if (legal && w && ix >= 2) m_regs[d][ix] = wd;
    end
    check("ctrl_post", get_ctrl(d), m_regs[d][2]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    model_reset();

    // Reset state
    #2;
    check("rst_pready", {31'd0, pready0}, 32'd0);
    check("rst_prdata", prdata0, 32'd0);
    check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    check("rst_ctrl", ctrl0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // ID / CNT / RW reads after reset
    xfer(0, 32'h00, 1'b0, '0);
    xfer(0, 32'h04, 1'b0, '0);
    xfer(0, 32'h08, 1'b0, '0);

    // Write, readback, counter
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF);
    xfer(0, 32'h08, 1'b0, '0);
    xfer(0, 32'h04, 1'b0, '0);
    xfer(0, 32'h1C, 1'b1, 32'h0BAD_F00D);
    xfer(0, 32'h1C, 1'b0, '0);

    // Illegal accesses and RO writes
    xfer(0, 32'h20, 1'b1, 32'h1111_2222);
    xfer(0, 32'h09, 1'b0, '0);
    xfer(0, 32'h108, 1'b0, '0);
    xfer(0, 32'h00, 1'b1, 32'hFFFF_FFFF);
    xfer(0, 32'h04, 1'b1, 32'h0000_0077);
    xfer(0, 32'h00, 1'b0, '0);
    xfer(0, 32'h04, 1'b0, '0);
    xfer(0, 32'h08, 1'b0, '0);

    // Zero-wait-state build, back-to-back write/read pairs
    for (int k = 0; k < 10; k++) begin
      rnd = 32'($urandom_range(0, 15));
      xfer(1, 32'h08 + 32'(4 * (k % 6)), 1'b1, rnd);
      xfer(1, 32'h08 + 32'(4 * (k % 6)), 1'b0, '0);
    end
    xfer(1, 32'h04, 1'b0, '0);

    // Enable without a setup cycle is ignored
    psel0 = 1'b1; penable = 1'b1; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("noset_pready", {31'd0, pready0}, 32'd0);
    end
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
    xfer(0, 32'h04, 1'b0, '0);
    xfer(0, 32'h0C, 1'b0, '0);

    // Reset asserted in the middle of an access
    psel0 = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h1234_5678;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_pready", {31'd0, pready0}, 32'd0);
    check("midrst_prdata", prdata0, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr0}, 32'd0);
    check("midrst_ctrl", ctrl0, 32'd0);
    check("midrst_ctrl1", ctrl1, 32'd0);
    psel0 = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h04, 1'b0, '0);
    xfer(0, 32'h0C, 1'b0, '0);
    xfer(0, 32'h08, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
